// File: rtl/window_fifo_2d_pkg.sv
// Shared Sobel pipeline types and window geometry helpers.
package sobel_pkg;

    localparam int DATAWIDTH = 8;

    typedef logic [DATAWIDTH-1:0] pixel_t;

    // Total packed width of a PIXEL x ROW_LOOP window.
    function automatic int win_width(input int dw, input int px, input int rl);
        return dw * px * rl;
    endfunction

    // Bit offset of lane (i,j) inside a packed window.
    function automatic int lane_off(input int dw, input int rl, input int i, input int j);
        return dw * (rl * i + j);
    endfunction

endpackage

// File: rtl/window_fifo_2d_if.sv
// Window stream bus: upstream push side, downstream pop side and flush.
interface window_fifo_2d_if #(
    parameter int PIXEL     = 3,
    parameter int ROW_LOOP  = 3,
    parameter int DATAWIDTH = sobel_pkg::DATAWIDTH
) ();
    import sobel_pkg::*;

    localparam int W = win_width(DATAWIDTH, PIXEL, ROW_LOOP);

    logic [W-1:0] packed_in;
    logic         in_tlast;
    logic         in_tuser;
    logic         i_strobe;
    logic         o_busy;
    logic [W-1:0] packed_out;
    logic         out_tlast;
    logic         out_tuser;
    logic         o_strobe;
    logic         i_busy;
    logic         i_flush;

    // FIFO side.
    modport slave (
        input  packed_in, in_tlast, in_tuser, i_strobe, i_busy, i_flush,
        output o_busy, packed_out, out_tlast, out_tuser, o_strobe
    );

    // Environment side: drives the stream in and consumes the stream out.
    modport master (
        output packed_in, in_tlast, in_tuser, i_strobe, i_busy, i_flush,
        input  o_busy, packed_out, out_tlast, out_tuser, o_strobe
    );

endinterface

// File: rtl/window_fifo_2d_wrap_ptr.sv
// Modulo-DEPTH pointer: increments on en, wraps DEPTH-1 -> 0, sync clear.
module wrap_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          ARESETN,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    // Clear (reset or flush) wins over increment.
    always_ff @(posedge clk) begin
        if (!ARESETN || clr)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end

endmodule

// File: rtl/window_fifo_2d.sv
// DEPTH-entry elastic buffer for packed pixel windows with tlast/tuser
// sidebands and synchronous flush. 1 window/clk, registered o_busy.
// Optional: WINDOW_FIFO_LEVEL_EN adds o_level (fill) and o_peak
// (high-water mark since reset or flush).
module window_fifo_2d
    import sobel_pkg::*;
#(
    parameter int PIXEL     = 3,
    parameter int ROW_LOOP  = 3,
    parameter int DATAWIDTH = sobel_pkg::DATAWIDTH,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       ARESETN,
    window_fifo_2d_if.slave            bus
`ifdef WINDOW_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic [$clog2(DEPTH+1)-1:0] o_peak
`endif
);

    localparam int W  = win_width(DATAWIDTH, PIXEL, ROW_LOOP);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry layout: {tuser, tlast, window}.
    logic [W+1:0]  mem [DEPTH];
    logic [W+1:0]  head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          busy_q;
    logic          out_zero;
    logic          push, pop;

    assign push = bus.i_strobe & ~busy_q;
    assign pop  = (count != '0) & ~bus.i_busy;

    // Fill level after this cycle's push/pop (flush handled separately).
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // Occupancy, registered not-ready, and post-reset output blanking.
    // out_zero masks stale storage until the first window lands after reset.
    always_ff @(posedge clk) begin
        if (!ARESETN) begin
            count    <= '0;
            busy_q   <= 1'b1;
            out_zero <= 1'b1;
        end else if (bus.i_flush) begin
            count    <= '0;
            busy_q   <= 1'b0;
        end else begin
            count    <= count_next;
            busy_q   <= (count_next == CW'(DEPTH));
            if (push)
                out_zero <= 1'b0;
        end
    end

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .ARESETN (ARESETN),
        .clr     (bus.i_flush),
        .en      (push),
        .ptr     (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .ARESETN (ARESETN),
        .clr     (bus.i_flush),
        .en      (pop),
        .ptr     (rd_ptr)
    );

    // Storage write; a push coinciding with flush is dropped. Not reset.
    always_ff @(posedge clk) begin
        if (push && !bus.i_flush)
            mem[wr_ptr] <= {bus.in_tuser, bus.in_tlast, bus.packed_in};
    end

    assign head           = mem[rd_ptr];
    assign bus.o_strobe   = (count != '0);
    assign bus.o_busy     = busy_q;
    assign bus.packed_out = out_zero ? '0   : head[W-1:0];
    assign bus.out_tlast  = out_zero ? 1'b0 : head[W];
    assign bus.out_tuser  = out_zero ? 1'b0 : head[W+1];

`ifdef WINDOW_FIFO_LEVEL_EN
    localparam int LW = $clog2(DEPTH + 1);

    logic [LW-1:0] peak;

    // High-water mark tracks count_next so it moves in step with count.
    always_ff @(posedge clk) begin
        if (!ARESETN || bus.i_flush)
            peak <= '0;
        else if (LW'(count_next) > peak)
            peak <= LW'(count_next);
    end

    assign o_level = LW'(count);
    assign o_peak  = peak;
`endif

endmodule

// File: tb/tb_window_fifo_2d.sv
// Directed + scoreboard bench for window_fifo_2d (DEPTH=4, 3x3x8 windows).
module tb_window_fifo_2d;
    import sobel_pkg::*;

    localparam int PIXEL    = 3;
    localparam int ROW_LOOP = 3;
    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int W        = PIXEL * ROW_LOOP * DW;
    localparam int NLANE    = PIXEL * ROW_LOOP;

    logic clk = 1'b0;
    logic ARESETN;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    window_fifo_2d_if #(.PIXEL(PIXEL), .ROW_LOOP(ROW_LOOP), .DATAWIDTH(DW)) bus ();

`ifdef WINDOW_FIFO_LEVEL_EN
    logic [2:0] o_level, o_peak;
`endif

    window_fifo_2d #(.PIXEL(PIXEL), .ROW_LOOP(ROW_LOOP), .DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .ARESETN (ARESETN),
        .bus     (bus)
`ifdef WINDOW_FIFO_LEVEL_EN
        ,
        .o_level (o_level),
        .o_peak  (o_peak)
`endif
    );

    // Window k carries lane value k+lane in every lane.
    function automatic logic [W-1:0] mkwin(input int k);
        logic [W-1:0] w;
        w = '0;
        for (int l = 0; l < NLANE; l++)
            w[DW*l +: DW] = 8'(k + l);
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stb, input int k);
        bus.i_strobe  = stb;
        bus.packed_in = mkwin(k);
        bus.in_tlast  = 1'b0;
        bus.in_tuser  = 1'b0;
    endtask

    logic [W+1:0] sb[$];
    logic [W+1:0] exp_e;
    int sent, recv, cyc;
    logic [W-1:0] pw;

    initial begin
        ARESETN     = 1'b0;
        bus.i_busy  = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b0, 0);

        // Reset state.
        tick();
        check("rst_strobe", 128'(bus.o_strobe), 128'(0));
        check("rst_busy",   128'(bus.o_busy),   128'(1));
        check("rst_data",   128'(bus.packed_out), 128'(0));
        check("rst_tlast",  128'(bus.out_tlast), 128'(0));
        check("rst_tuser",  128'(bus.out_tuser), 128'(0));
        ARESETN = 1'b1;
        tick();
        check("rel_busy", 128'(bus.o_busy), 128'(0));

        // 1: streaming, output is input delayed one clock.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k);
            tick();
            check("t1_strobe", 128'(bus.o_strobe), 128'(1));
            check("t1_data",   128'(bus.packed_out), 128'(mkwin(k)));
            check("t1_busy",   128'(bus.o_busy), 128'(0));
            pw = bus.packed_out;
            check("t1_lane12", 128'(pw[lane_off(DW, ROW_LOOP, 1, 2) +: DW]), 128'(8'(k + 5)));
        end
        drive(1'b0, 0);
        tick();
        check("t1_drain", 128'(bus.o_strobe), 128'(0));

        // 2: fill under backpressure, then drain.
        bus.i_busy = 1'b1;
        for (int k = 10; k < 14; k++) begin
            drive(1'b1, k);
            tick();
            check("t2_busy_fill", 128'(bus.o_busy), 128'(k == 13));
        end
        drive(1'b1, 14);
        tick();
        check("t2_full_busy", 128'(bus.o_busy), 128'(1));
        check("t2_hold",      128'(bus.packed_out), 128'(mkwin(10)));
        bus.i_busy = 1'b0;
        tick();
        check("t2_pop0",   128'(bus.packed_out), 128'(mkwin(11)));
        check("t2_unbusy", 128'(bus.o_busy), 128'(0));
        tick();
        check("t2_pop1", 128'(bus.packed_out), 128'(mkwin(12)));
        drive(1'b0, 0);
        tick();
        check("t2_pop2", 128'(bus.packed_out), 128'(mkwin(13)));
        tick();
        check("t2_fifth", 128'(bus.packed_out), 128'(mkwin(14)));
        tick();
        check("t2_empty", 128'(bus.o_strobe), 128'(0));

`ifdef WINDOW_FIFO_LEVEL_EN
        // 6: level / peak.
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_busy  = 1'b1;
        for (int k = 30; k < 33; k++) begin
            drive(1'b1, k);
            tick();
        end
        drive(1'b0, 0);
        bus.i_busy = 1'b0;
        tick();
        tick();
        bus.i_busy = 1'b1;
        check("t6_level", 128'(o_level), 128'(1));
        check("t6_peak",  128'(o_peak),  128'(3));
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("t6_level_fl", 128'(o_level), 128'(0));
        check("t6_peak_fl",  128'(o_peak),  128'(0));
`endif

        // 4: flush with simultaneous push.
        bus.i_busy = 1'b1;
        for (int k = 20; k < 23; k++) begin
            drive(1'b1, k);
            tick();
        end
        check("t4_held", 128'(bus.o_strobe), 128'(1));
        drive(1'b1, 23);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        check("t4_fl_strobe", 128'(bus.o_strobe), 128'(0));
        check("t4_fl_busy",   128'(bus.o_busy),   128'(0));
        drive(1'b1, 24);
        tick();
        drive(1'b0, 0);
        check("t4_next_strobe", 128'(bus.o_strobe), 128'(1));
        check("t4_next_data",   128'(bus.packed_out), 128'(mkwin(24)));
        bus.i_busy = 1'b0;
        tick();
        check("t4_empty", 128'(bus.o_strobe), 128'(0));

        // 5: mid-stream reset with two entries held.
        bus.i_busy = 1'b1;
        for (int k = 40; k < 42; k++) begin
            drive(1'b1, k);
            tick();
        end
        drive(1'b0, 0);
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        check("t5_rst_strobe", 128'(bus.o_strobe), 128'(0));
        check("t5_rst_busy",   128'(bus.o_busy),   128'(1));
        check("t5_rst_data",   128'(bus.packed_out), 128'(0));
        tick();
        check("t5_rel_busy",   128'(bus.o_busy),   128'(0));
        check("t5_rel_strobe", 128'(bus.o_strobe), 128'(0));
        bus.i_busy = 1'b0;
        drive(1'b1, 42);
        tick();
        drive(1'b0, 0);
        check("t5_first", 128'(bus.packed_out), 128'(mkwin(42)));
        tick();
        check("t5_empty", 128'(bus.o_strobe), 128'(0));

        // 3: random handshake against a scoreboard queue.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 3000 && cyc < 40000) begin
            bus.i_strobe  = (sent < 3000) && ($urandom_range(0, 1) == 1);
            bus.packed_in = mkwin(sent * 7);
            bus.in_tlast  = (sent % 640 == 639);
            bus.in_tuser  = (sent % 640 == 0);
            bus.i_busy    = ($urandom_range(0, 1) == 1);
            if (bus.o_strobe && !bus.i_busy) begin
                if (sb.size() == 0) begin
                    check("t3_underflow", 128'(1), 128'(0));
                end else begin
                    exp_e = sb.pop_front();
                    check("t3_word", 128'({bus.out_tuser, bus.out_tlast, bus.packed_out}), 128'(exp_e));
                end
                recv++;
            end
            if (bus.i_strobe && !bus.o_busy) begin
                sb.push_back({bus.in_tuser, bus.in_tlast, bus.packed_in});
                sent++;
            end
            tick();
            cyc++;
        end
        check("t3_count", 128'(recv), 128'(3000));
        check("t3_left",  128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
